// File: rtl/asym_sync_fifo.sv
// Single-clock FIFO, narrow write port packed little-endian into a wide read port over an inferred BRAM.
// Optional sticky overflow/underflow outputs are enabled by defining ASYM_FIFO_ERR_FLAGS_EN.
module asym_sync_fifo #(
  parameter int C_WR_WIDTH           = 16,
  parameter int C_RD_WIDTH           = 32,
  parameter int C_WR_DEPTH           = 1024,
  parameter int C_FWFT               = 0,
  parameter int C_ALMOST_FULL_THRESH = 1000,
  localparam int R     = C_RD_WIDTH / C_WR_WIDTH,
  localparam int LOG2R = $clog2(R),
  localparam int AW    = $clog2(C_WR_DEPTH),
  localparam int RAW   = $clog2(C_WR_DEPTH / R),
  localparam int CW    = AW + 1,
  localparam int RCW   = RAW + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wren,
  input  logic [C_WR_WIDTH-1:0] din,
  output logic                  full,
  output logic                  almost_full,
  output logic [CW-1:0]         wr_count,
  input  logic                  rden,
  output logic [C_RD_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  empty,
`ifdef ASYM_FIFO_ERR_FLAGS_EN
  output logic [RCW-1:0]        rd_count,
  output logic                  overflow,
  output logic                  underflow
`else
  output logic [RCW-1:0]        rd_count
`endif
);

  localparam int RD_DEPTH = C_WR_DEPTH / R;
  localparam int LW       = (LOG2R > 0) ? LOG2R : 1;
  localparam logic [CW-1:0] R_CNT      = CW'(R);
  localparam logic [CW-1:0] DEPTH_CNT  = CW'(C_WR_DEPTH);
  localparam logic [CW-1:0] THRESH_CNT = CW'(C_ALMOST_FULL_THRESH);

  logic [C_RD_WIDTH-1:0] mem [RD_DEPTH];

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [RAW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         wr_count_q, wr_count_d;
  logic                  full_q, full_d;
  logic                  almost_full_q, almost_full_d;
  logic                  empty_q, empty_d;
  logic                  dout_valid_q, dout_valid_d;
  logic [C_RD_WIDTH-1:0] dout_q;
  logic                  wr_acc, rd_acc, ram_rd;
  logic [RCW-1:0]        ram_words;
  logic [RAW-1:0]        wr_addr;
  logic [LW-1:0]         wr_lane;

  assign wr_addr = wr_ptr_q[AW-1:LOG2R];

  generate
    if (LOG2R > 0) begin : g_lane
      assign wr_lane = wr_ptr_q[LW-1:0];
    end else begin : g_no_lane
      assign wr_lane = 1'b0;
    end
  endgenerate

  always_comb begin
    wr_acc       = wren && !full_q;
    // In FWFT mode empty_q mirrors !dout_valid_q, so this is also the pop condition.
    rd_acc       = rden && !empty_q;
    // Complete words still in RAM, excluding the one parked in the output register.
    ram_words    = wr_count_q[AW:LOG2R] - RCW'(dout_valid_q);
    ram_rd       = rd_acc;
    dout_valid_d = rd_acc;
    wr_count_d   = wr_count_q + CW'(wr_acc) - (rd_acc ? R_CNT : '0);
    empty_d      = (wr_count_d < R_CNT);
    if (C_FWFT != 0) begin
      ram_rd       = (!dout_valid_q || rd_acc) && (ram_words != '0);
      dout_valid_d = ram_rd || (dout_valid_q && !rd_acc);
      empty_d      = !dout_valid_d;
    end
    full_d        = (wr_count_d == DEPTH_CNT);
    almost_full_d = (wr_count_d >= THRESH_CNT);
    wr_ptr_d      = wr_ptr_q + AW'(wr_acc);
    rd_ptr_d      = rd_ptr_q + RAW'(ram_rd);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      wr_count_q    <= '0;
      full_q        <= 1'b0;
      almost_full_q <= 1'b0;
      empty_q       <= 1'b1;
      dout_valid_q  <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_count_q    <= wr_count_d;
      full_q        <= full_d;
      almost_full_q <= almost_full_d;
      empty_q       <= empty_d;
      dout_valid_q  <= dout_valid_d;
    end
  end

  // Narrow write lands in one lane of the wide word; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int i = 0; i < R; i++) begin
        if (wr_lane == LW'(i)) begin
          mem[wr_addr][i*C_WR_WIDTH +: C_WR_WIDTH] <= din;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= '0;
    end else if (ram_rd) begin
      dout_q <= mem[rd_ptr_q];
    end
  end

  assign full        = full_q;
  assign almost_full = almost_full_q;
  assign wr_count    = wr_count_q;
  assign rd_count    = wr_count_q[AW:LOG2R];
  assign dout        = dout_q;
  assign dout_valid  = dout_valid_q;
  assign empty       = empty_q;

`ifdef ASYM_FIFO_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q || (wren && full_q);
    underflow_d = underflow_q || (rden && empty_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_asym_sync_fifo.sv
// Drives a standard-mode and an FWFT-mode FIFO (R=2, depth 8, threshold 6) with identical stimulus
// and compares both against queue-based reference models.
module tb_asym_sync_fifo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wren = 1'b0;
  logic        rden = 1'b0;
  logic [15:0] din = '0;

  logic        full_s, af_s, dv_s, empty_s;
  logic [3:0]  wrc_s;
  logic [2:0]  rdc_s;
  logic [31:0] dout_s;
  logic        full_f, af_f, dv_f, empty_f;
  logic [3:0]  wrc_f;
  logic [2:0]  rdc_f;
  logic [31:0] dout_f;
`ifdef ASYM_FIFO_ERR_FLAGS_EN
  logic        ovf_s, unf_s, ovf_f, unf_f;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  asym_sync_fifo #(.C_WR_WIDTH(16), .C_RD_WIDTH(32), .C_WR_DEPTH(8), .C_FWFT(0),
                   .C_ALMOST_FULL_THRESH(6)) u_std (
    .clk(clk), .rst_n(rst_n), .wren(wren), .din(din), .full(full_s), .almost_full(af_s),
    .wr_count(wrc_s), .rden(rden), .dout(dout_s), .dout_valid(dv_s), .empty(empty_s),
`ifdef ASYM_FIFO_ERR_FLAGS_EN
    .rd_count(rdc_s), .overflow(ovf_s), .underflow(unf_s)
`else
    .rd_count(rdc_s)
`endif
  );

  asym_sync_fifo #(.C_WR_WIDTH(16), .C_RD_WIDTH(32), .C_WR_DEPTH(8), .C_FWFT(1),
                   .C_ALMOST_FULL_THRESH(6)) u_fwft (
    .clk(clk), .rst_n(rst_n), .wren(wren), .din(din), .full(full_f), .almost_full(af_f),
    .wr_count(wrc_f), .rden(rden), .dout(dout_f), .dout_valid(dv_f), .empty(empty_f),
`ifdef ASYM_FIFO_ERR_FLAGS_EN
    .rd_count(rdc_f), .overflow(ovf_f), .underflow(unf_f)
`else
    .rd_count(rdc_f)
`endif
  );

  // Reference state: every accepted write word not yet popped, in order.
  logic [15:0] q_s[$];
  logic [15:0] q_f[$];
  logic [31:0] m_dout_s, m_dout_f;
  logic        m_valid_s, m_valid_f;
  logic        m_ovf_s, m_unf_s, m_ovf_f, m_unf_f;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q_s.delete();
    q_f.delete();
    m_dout_s = '0; m_dout_f = '0;
    m_valid_s = 1'b0; m_valid_f = 1'b0;
    m_ovf_s = 1'b0; m_unf_s = 1'b0; m_ovf_f = 1'b0; m_unf_f = 1'b0;
  endtask

  task automatic model_step(input logic w, input logic r, input logic [15:0] d);
    int  sz;
    int  avail;
    logic pop;
    // Standard mode: a read needs a complete pair stored before the edge.
    sz = q_s.size();
    m_ovf_s = m_ovf_s | (w && sz == 8);
    m_unf_s = m_unf_s | (r && sz < 2);
    m_valid_s = 1'b0;
    if (r && sz >= 2) begin
      m_dout_s = {q_s[1], q_s[0]};
      void'(q_s.pop_front());
      void'(q_s.pop_front());
      m_valid_s = 1'b1;
    end
    if (w && sz < 8) q_s.push_back(d);
    // FWFT mode: the held pair is still counted in the queue.
    sz = q_f.size();
    avail = sz / 2 - (m_valid_f ? 1 : 0);
    pop = r && m_valid_f;
    m_ovf_f = m_ovf_f | (w && sz == 8);
    m_unf_f = m_unf_f | (r && !m_valid_f);
    if (pop) begin
      void'(q_f.pop_front());
      void'(q_f.pop_front());
    end
    if ((!m_valid_f || pop) && avail > 0) begin
      m_dout_f = {q_f[1], q_f[0]};
      m_valid_f = 1'b1;
    end else if (pop) begin
      m_valid_f = 1'b0;
    end
    if (w && sz < 8) q_f.push_back(d);
  endtask

  task automatic check_all(input string step);
    int ns, nf;
    ns = q_s.size();
    nf = q_f.size();
    chk({step, " std.wr_count"}, 32'(wrc_s), 32'(ns));
    chk({step, " std.rd_count"}, 32'(rdc_s), 32'(ns / 2));
    chk({step, " std.full"}, 32'(full_s), 32'(ns == 8));
    chk({step, " std.almost_full"}, 32'(af_s), 32'(ns >= 6));
    chk({step, " std.empty"}, 32'(empty_s), 32'(ns < 2));
    chk({step, " std.dout_valid"}, 32'(dv_s), 32'(m_valid_s));
    chk({step, " std.dout"}, dout_s, m_dout_s);
    chk({step, " fwft.wr_count"}, 32'(wrc_f), 32'(nf));
    chk({step, " fwft.rd_count"}, 32'(rdc_f), 32'(nf / 2));
    chk({step, " fwft.full"}, 32'(full_f), 32'(nf == 8));
    chk({step, " fwft.almost_full"}, 32'(af_f), 32'(nf >= 6));
    chk({step, " fwft.empty"}, 32'(empty_f), 32'(!m_valid_f));
    chk({step, " fwft.dout_valid"}, 32'(dv_f), 32'(m_valid_f));
    chk({step, " fwft.dout"}, dout_f, m_dout_f);
`ifdef ASYM_FIFO_ERR_FLAGS_EN
    chk({step, " std.overflow"}, 32'(ovf_s), 32'(m_ovf_s));
    chk({step, " std.underflow"}, 32'(unf_s), 32'(m_unf_s));
    chk({step, " fwft.overflow"}, 32'(ovf_f), 32'(m_ovf_f));
    chk({step, " fwft.underflow"}, 32'(unf_f), 32'(m_unf_f));
`endif
  endtask

  task automatic cycle(input string step, input logic w, input logic r, input logic [15:0] d);
    @(negedge clk);
    wren = w;
    rden = r;
    din  = d;
    @(posedge clk);
    model_step(w, r, d);
    #1;
    check_all(step);
    $display("%s: wren=%0b rden=%0b din=%h | std wc=%0d dv=%0b dout=%h | fwft wc=%0d dv=%0b dout=%h",
             step, w, r, d, wrc_s, dv_s, dout_s, wrc_f, dv_f, dout_f);
  endtask

  // Reset asserted between edges; outputs must clear without waiting for a clock.
  task automatic mid_reset(input string step);
    @(negedge clk);
    wren = 1'b0;
    rden = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all(step);
    $display("%s: async reset pulse", step);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #12;
    check_all("por");
    $display("por: reset held");
    @(negedge clk);
    rst_n = 1'b1;

    cycle("t1.w0", 1'b1, 1'b0, 16'h1111);
    cycle("t1.w1", 1'b1, 1'b0, 16'h2222);
    cycle("t1.rd", 1'b0, 1'b1, 16'h0000);
    cycle("t1.idle", 1'b0, 1'b0, 16'h0000);

    mid_reset("t2.rst");
    cycle("t2.wA", 1'b1, 1'b0, 16'hAAAA);
    cycle("t2.wB", 1'b1, 1'b0, 16'hBBBB);
    cycle("t2.wC", 1'b1, 1'b0, 16'hCCCC);
    cycle("t2.rd", 1'b0, 1'b1, 16'h0000);
    cycle("t2.rd_partial", 1'b0, 1'b1, 16'h0000);
    cycle("t2.wD", 1'b1, 1'b0, 16'hDDDD);
    cycle("t2.rd2", 1'b0, 1'b1, 16'h0000);
    cycle("t2.idle", 1'b0, 1'b0, 16'h0000);

    mid_reset("t3.rst");
    for (int i = 0; i < 9; i++) cycle("t3.fill", 1'b1, 1'b0, 16'(16'h3000 + i));
    for (int i = 0; i < 5; i++) cycle("t3.drain", 1'b0, 1'b1, 16'h0000);
    cycle("t3.idle", 1'b0, 1'b0, 16'h0000);

    mid_reset("t4.rst");
    for (int i = 0; i < 8; i++) cycle("t4.fill", 1'b1, 1'b0, 16'(16'h4000 + i));
    cycle("t4.rw_full", 1'b1, 1'b1, 16'h4F00);
    cycle("t4.w_after", 1'b1, 1'b0, 16'h4F01);
    for (int i = 0; i < 5; i++) cycle("t4.drain", 1'b0, 1'b1, 16'h0000);

    mid_reset("t5.rst");
    for (int i = 0; i < 4; i++) cycle("t5.w", 1'b1, 1'b0, 16'(16'h5000 + i));
    cycle("t5.settle", 1'b0, 1'b0, 16'h0000);
    cycle("t5.pop0", 1'b0, 1'b1, 16'h0000);
    cycle("t5.pop1", 1'b0, 1'b1, 16'h0000);
    cycle("t5.idle", 1'b0, 1'b0, 16'h0000);

    mid_reset("t6.rst0");
    for (int i = 0; i < 6; i++) cycle("t6.fill", 1'b1, 1'b0, 16'(16'h6000 + i));
    mid_reset("t6.rst_mid");
    cycle("t6.rd_empty", 1'b0, 1'b1, 16'h0000);
    cycle("t6.idle", 1'b0, 1'b0, 16'h0000);

    // Random traffic, alternating between fill-biased and drain-biased phases.
    mid_reset("rnd.rst");
    for (int ph = 0; ph < 8; ph++) begin
      for (int i = 0; i < 50; i++) begin
        int pw;
        int pr;
        pw = ph[0] ? 30 : 80;
        pr = ph[0] ? 80 : 30;
        cycle("rnd", 1'($urandom_range(0, 99) < pw), 1'($urandom_range(0, 99) < pr),
              16'($urandom));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/asym_sync_fifo.md
Name: asym_sync_fifo

Overview:
- Single-clock FIFO with a narrow write port and a wide read port, built on an inferred simple-dual-port BRAM.
- Successor to the two-clock asymmetric RAM. Adds pointer management, full/empty/almost-full flags, occupancy counts and a run-time-free FWFT mode, so feature-map and weight streams can be packed from C_WR_WIDTH to C_RD_WIDTH without external address logic.

Parameters:
- C_WR_WIDTH, 16: write word width in bits.
- C_RD_WIDTH, 32: read word width in bits. Ratio R = C_RD_WIDTH/C_WR_WIDTH must be a power of 2 and at least 1.
- C_WR_DEPTH, 1024: capacity in write words. Must be a power of 2 and a multiple of R.
- C_FWFT, 0: 1 = first-word-fall-through output, 0 = standard read with 1-cycle latency.
- C_ALMOST_FULL_THRESH, 1000: almost_full asserts when wr_count >= this value. Legal range is 1..C_WR_DEPTH.

Ports:
- clk, in, 1: single clock.
- rst_n, in, 1: asynchronous active-low reset.
- wren, in, 1: write request.
- din, in, C_WR_WIDTH: write data.
- full, out, 1: no space for another write word.
- almost_full, out, 1: wr_count >= C_ALMOST_FULL_THRESH.
- wr_count, out, clog2(C_WR_DEPTH)+1: stored write words not yet popped.
- rden, in, 1: read request (standard mode) or pop (FWFT mode).
- dout, out, C_RD_WIDTH: read data.
- dout_valid, out, 1: dout holds a valid word this cycle.
- empty, out, 1: no complete read word available.
- rd_count, out, clog2(C_WR_DEPTH/R)+1: complete read words available, equal to floor(wr_count/R).

Behaviour:
- Reset, asynchronous and immediate on rst_n low:
  - pointers and counts go to 0; full=0, almost_full=0, empty=1, dout_valid=0, dout=0.
  - RAM contents are not cleared.
  - Reset mid-transfer discards all stored data and any partial read word.
- Write:
  - accepted when wren && !full; din is stored at wr_ptr and wr_ptr increments, wrapping modulo C_WR_DEPTH.
  - wren while full is ignored: no pointer change, no corruption.
- Packing: the first write word of each group of R goes to bits [C_WR_WIDTH-1:0] of the read word, the next to the next slice up, and so on (little-endian).
- Read pointer: counts read words and wraps modulo C_WR_DEPTH/R. An incomplete group of fewer than R write words is never readable.
- Standard mode (C_FWFT=0):
  - read accepted when rden && !empty.
  - dout is registered and valid on the cycle after acceptance, with dout_valid=1 for exactly that cycle.
  - dout holds its last value otherwise.
  - rden while empty is ignored and dout_valid stays 0.
- FWFT mode (C_FWFT=1):
  - an output register is prefetched from RAM whenever it is empty or being popped and a complete word is stored.
  - empty = !dout_valid.
  - rden && dout_valid pops the word; the next word, if any, appears the following cycle with no bubble when RAM holds it.
- Flag timing, all registered and updated on the same edge as the accepted operation:
  - full = (wr_count == C_WR_DEPTH).
  - In standard mode, empty deasserts on the edge of the write completing the R-th word. In FWFT mode it deasserts one edge later.
- Simultaneous write and read:
  - both are honoured when individually legal; wr_count changes by +1 - R.
  - A read while full frees R slots on that edge; a write in the same cycle as full is still rejected because the flag is registered.
  - A write completing a group while empty does not permit a read in the same cycle.
- Counts: wr_count includes any word held in the FWFT output register.

Optional Feature:
- Macro: ASYM_FIFO_ERR_FLAGS_EN.
- When defined, two extra output ports are added:
  - overflow, 1 bit: sticky, set when wren && full.
  - underflow, 1 bit: sticky, set when rden && empty.
  - Both are cleared only by rst_n.
- When undefined, neither port exists and illegal requests are silently ignored.

Test Plan (R=2, C_WR_DEPTH=8, C_ALMOST_FULL_THRESH=6):
- Reset, then write 16'h1111 and 16'h2222, C_FWFT=0 -> empty drops after the 2nd write; rden returns dout=32'h2222_1111 with dout_valid=1 one cycle later; empty=1 and wr_count=0 again.
- Write 3 words (A,B,C) -> rd_count=1, wr_count=3. Read once -> dout={B,A}, rd_count=0, empty=1, wr_count=1; C stays unreadable until D is written.
- Write 8 words -> almost_full at wr_count=6, full at 8. A 9th write is ignored (overflow=1 with macro). Read 4 words -> data in order, pointers wrap, empty=1.
- At full, assert wren and rden together -> read accepted, write rejected, wr_count=6. Next cycle a write is accepted and wr_count=7.
- C_FWFT=1: write 4 words -> dout={w1,w0} valid 2 edges after w1. Hold rden 2 cycles -> {w1,w0} then {w3,w2} back-to-back, then empty=1.
- Fill 6 words, pulse rst_n low mid-cycle -> flags and counts reset immediately (empty=1, full=0, dout_valid=0). After release, a single read request is ignored (underflow=1 with macro).
